// File: rtl/alu_op_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : alu_op_sequencer
// Purpose  : Issue/capture stage wrapped around a combinational ALU. Operands
//            are registered onto the ALU inputs on accept, the ALU result and
//            flags are captured one cycle later and offered downstream. The
//            stored flags feed back as ALU flag-in for carry chaining.
// Revision : 1.0 - initial release
// ============================================================================
module alu_op_sequencer #(
  parameter int ANCHO = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [ANCHO-1:0] in_a,
  input  logic [ANCHO-1:0] in_b,
  input  logic [4:0]       in_ctrl,
  input  logic             flag_clr,
  output logic [ANCHO-1:0] alu_a,
  output logic [ANCHO-1:0] alu_b,
  output logic [4:0]       alu_control,
  output logic [1:0]       alu_flag_in,
  input  logic [ANCHO-1:0] alu_result,
  input  logic             alu_c,
  input  logic             alu_z,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [ANCHO-1:0] res_data,
  output logic             flag_c,
  output logic             flag_z,
  output logic [CNT_W-1:0] op_count
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_next;
  logic   w_accept;

  // A transaction is taken whenever upstream offers one while we can take it.
  assign w_accept    = in_valid & in_ready;

  // Stored flags drive the ALU flag-in directly, so EXEC sees the previous op's flags.
  assign alu_flag_in = {flag_z, flag_c};

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state and handshake outputs; in_ready depends only on state and res_ready.
  always_comb begin
    w_state_next = r_state;
    in_ready     = 1'b0;
    res_valid    = 1'b0;
    case (r_state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          w_state_next = EXEC;
        end
      end
      EXEC: begin
        w_state_next = DONE;
      end
      DONE: begin
        res_valid = 1'b1;
        in_ready  = res_ready;
        if (res_ready) begin
          w_state_next = in_valid ? EXEC : IDLE;
        end
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  // Operand latch on accept; result/flag capture and op count at the end of EXEC.
  always_ff @(posedge clk) begin
    if (rst) begin
      alu_a       <= '0;
      alu_b       <= '0;
      alu_control <= '0;
      res_data    <= '0;
      flag_c      <= 1'b0;
      flag_z      <= 1'b0;
      op_count    <= '0;
    end else begin
      if (w_accept) begin
        alu_a       <= in_a;
        alu_b       <= in_b;
        alu_control <= in_ctrl;
      end
      // Capture takes priority over a coincident flag clear.
      if (r_state == EXEC) begin
        res_data <= alu_result;
        flag_c   <= alu_c;
        flag_z   <= alu_z;
        op_count <= op_count + {{(CNT_W-1){1'b0}}, 1'b1};
      end else if (flag_clr) begin
        flag_c <= 1'b0;
        flag_z <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_alu_op_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_op_sequencer
// Purpose  : Self-checking bench for alu_op_sequencer with an ALU stub and a
//            transaction-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_op_sequencer;

  localparam int ANCHO = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             in_valid = 1'b0;
  logic [ANCHO-1:0] in_a = '0;
  logic [ANCHO-1:0] in_b = '0;
  logic [4:0]       in_ctrl = '0;
  logic             flag_clr = 1'b0;
  logic             res_ready = 1'b0;

  logic             in_ready, res_valid, flag_c, flag_z, alu_c, alu_z;
  logic [ANCHO-1:0] alu_a, alu_b, alu_result, res_data;
  logic [4:0]       alu_control;
  logic [1:0]       alu_flag_in;
  logic [7:0]       op_count;

  logic             in_ready2, res_valid2, flag_c2, flag_z2, alu_c2, alu_z2;
  logic [ANCHO-1:0] alu_a2, alu_b2, alu_result2, res_data2;
  logic [4:0]       alu_control2;
  logic [1:0]       alu_flag_in2;
  logic [1:0]       op_count2;

  int tests_run = 0;
  int fails = 0;

  // Reference model state: last accepted operands, stored flags/result, op count.
  logic [ANCHO-1:0] m_a, m_b, m_res;
  logic [4:0]       m_ctrl;
  logic             m_fc, m_fz;
  int               m_cnt;

  always #5 clk = ~clk;

  alu_op_sequencer #(.ANCHO(ANCHO), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_ctrl(in_ctrl), .flag_clr(flag_clr),
    .alu_a(alu_a), .alu_b(alu_b), .alu_control(alu_control), .alu_flag_in(alu_flag_in),
    .alu_result(alu_result), .alu_c(alu_c), .alu_z(alu_z),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .flag_c(flag_c), .flag_z(flag_z), .op_count(op_count)
  );

  alu_op_sequencer #(.ANCHO(ANCHO), .CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready2),
    .in_a(in_a), .in_b(in_b), .in_ctrl(in_ctrl), .flag_clr(flag_clr),
    .alu_a(alu_a2), .alu_b(alu_b2), .alu_control(alu_control2), .alu_flag_in(alu_flag_in2),
    .alu_result(alu_result2), .alu_c(alu_c2), .alu_z(alu_z2),
    .res_valid(res_valid2), .res_ready(res_ready), .res_data(res_data2),
    .flag_c(flag_c2), .flag_z(flag_z2), .op_count(op_count2)
  );

  // ALU behaviour: add, plus carry-in when opcode bit 0 is set. Returns {z, c, result}.
  function automatic logic [ANCHO+1:0] alu_fn(input logic [ANCHO-1:0] a, input logic [ANCHO-1:0] b,
                                             input logic [4:0] ctrl, input logic [1:0] fin);
    logic [ANCHO:0] sum;
    sum = {1'b0, a} + {1'b0, b} + {{ANCHO{1'b0}}, (ctrl[0] & fin[0])};
    return {(sum[ANCHO-1:0] == '0), sum[ANCHO], sum[ANCHO-1:0]};
  endfunction

  // Combinational ALU stubs, one per instance.
  always_comb {alu_z, alu_c, alu_result} = alu_fn(alu_a, alu_b, alu_control, alu_flag_in);
  always_comb {alu_z2, alu_c2, alu_result2} = alu_fn(alu_a2, alu_b2, alu_control2, alu_flag_in2);

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; in_valid = 1'b0; flag_clr = 1'b0; res_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    m_a = '0; m_b = '0; m_ctrl = '0; m_res = '0; m_fc = 1'b0; m_fz = 1'b0; m_cnt = 0;
  endtask

  // Issue one op (from IDLE or DONE) and check the EXEC and DONE cycles against the model.
  task automatic issue(input logic [ANCHO-1:0] a, input logic [ANCHO-1:0] b,
                       input logic [4:0] ctrl, input bit clr_exec);
    logic [ANCHO+1:0] exp;
    in_a = a; in_b = b; in_ctrl = ctrl; in_valid = 1'b1; res_ready = 1'b1;
    #1;
    tests_run++; if (in_ready !== 1'b1) begin fails++; $display("FAIL accept_ready: got %b expected 1", in_ready); end
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0; in_a = ANCHO'($urandom); in_b = ANCHO'($urandom); in_ctrl = 5'($urandom);
    flag_clr = clr_exec;
    m_a = a; m_b = b; m_ctrl = ctrl;
    tests_run++; if ({alu_a, alu_b, alu_control} !== {a, b, ctrl}) begin fails++; $display("FAIL exec_operands: got %h/%h/%h expected %h/%h/%h", alu_a, alu_b, alu_control, a, b, ctrl); end
    tests_run++; if ({res_valid, in_ready} !== 2'b00) begin fails++; $display("FAIL exec_handshake: got valid=%b ready=%b expected 0/0", res_valid, in_ready); end
    tests_run++; if (alu_flag_in !== {m_fz, m_fc}) begin fails++; $display("FAIL exec_flag_in: got %b expected %b", alu_flag_in, {m_fz, m_fc}); end
    exp = alu_fn(a, b, ctrl, {m_fz, m_fc});
    @(posedge clk);
    m_res = exp[ANCHO-1:0]; m_fc = exp[ANCHO]; m_fz = exp[ANCHO+1]; m_cnt++;
    @(negedge clk);
    flag_clr = 1'b0;
    tests_run++; if (res_valid !== 1'b1) begin fails++; $display("FAIL done_valid: got %b expected 1", res_valid); end
    tests_run++; if ({res_data, flag_c, flag_z} !== {m_res, m_fc, m_fz}) begin fails++; $display("FAIL done_result: got %h c=%b z=%b expected %h c=%b z=%b", res_data, flag_c, flag_z, m_res, m_fc, m_fz); end
    tests_run++; if (op_count !== 8'(m_cnt)) begin fails++; $display("FAIL op_count: got %0d expected %0d", op_count, 8'(m_cnt)); end
    tests_run++; if (op_count2 !== 2'(m_cnt)) begin fails++; $display("FAIL op_count_w2: got %0d expected %0d", op_count2, 2'(m_cnt)); end
  endtask

  // Hold DONE with res_ready low for n cycles while upstream inputs wander.
  task automatic hold_done(input int n, input bit rand_clr);
    bit clr;
    for (int i = 0; i < n; i++) begin
      clr = rand_clr && ($urandom_range(0, 2) == 0);
      res_ready = 1'b0; flag_clr = clr; in_valid = 1'($urandom);
      in_a = ANCHO'($urandom); in_b = ANCHO'($urandom); in_ctrl = 5'($urandom);
      #1;
      tests_run++; if ({in_ready, res_valid} !== 2'b01) begin fails++; $display("FAIL hold_handshake: got ready=%b valid=%b expected 0/1", in_ready, res_valid); end
      @(posedge clk);
      if (clr) begin m_fc = 1'b0; m_fz = 1'b0; end
      @(negedge clk);
      flag_clr = 1'b0;
      tests_run++; if ({res_data, flag_c, flag_z, res_valid} !== {m_res, m_fc, m_fz, 1'b1}) begin fails++; $display("FAIL hold_result: got %h c=%b z=%b v=%b expected %h c=%b z=%b v=1", res_data, flag_c, flag_z, res_valid, m_res, m_fc, m_fz); end
      tests_run++; if ({alu_a, alu_b, alu_control, op_count} !== {m_a, m_b, m_ctrl, 8'(m_cnt)}) begin fails++; $display("FAIL hold_operands: got %h/%h/%h cnt=%0d expected %h/%h/%h cnt=%0d", alu_a, alu_b, alu_control, op_count, m_a, m_b, m_ctrl, 8'(m_cnt)); end
    end
    in_valid = 1'b0;
  endtask

  // Release DONE with no new op and sit in IDLE for n cycles.
  task automatic idle_gap(input int n);
    res_ready = 1'b1; in_valid = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      @(negedge clk);
      res_ready = 1'($urandom);
      #1;
      tests_run++; if ({res_valid, in_ready, res_data, flag_c, flag_z} !== {2'b01, m_res, m_fc, m_fz}) begin fails++; $display("FAIL idle_state: got v=%b r=%b %h c=%b z=%b expected v=0 r=1 %h c=%b z=%b", res_valid, in_ready, res_data, flag_c, flag_z, m_res, m_fc, m_fz); end
    end
  endtask

  task automatic test_reset();
    do_reset();
    tests_run++; if ({alu_a, alu_b, alu_control, res_data, flag_c, flag_z, op_count} !== '0) begin fails++; $display("FAIL reset_regs: got a=%h b=%h ctl=%h r=%h c=%b z=%b cnt=%0d expected all 0", alu_a, alu_b, alu_control, res_data, flag_c, flag_z, op_count); end
    tests_run++; if ({res_valid, in_ready, alu_flag_in} !== 4'b0100) begin fails++; $display("FAIL reset_ctrl: got v=%b r=%b fi=%b expected v=0 r=1 fi=00", res_valid, in_ready, alu_flag_in); end
  endtask

  task automatic test_basic();
    do_reset();
    issue(4'd2, 4'd3, 5'd0, 1'b0);
    tests_run++; if ({res_data, op_count} !== {4'd5, 8'd1}) begin fails++; $display("FAIL basic_result: got %0d cnt=%0d expected 5 cnt=1", res_data, op_count); end
  endtask

  task automatic test_backpressure();
    logic [ANCHO-1:0] held;
    held = m_res;
    hold_done(5, 1'b0);
    tests_run++; if (res_data !== held) begin fails++; $display("FAIL bp_hold: got %h expected %h", res_data, held); end
    issue(4'd7, 4'd4, 5'd0, 1'b0);
    issue(4'd1, 4'd6, 5'd0, 1'b0);
    tests_run++; if (res_data !== 4'd7) begin fails++; $display("FAIL back_to_back: got %0d expected 7", res_data); end
  endtask

  task automatic test_carry_chain();
    do_reset();
    issue(4'd8, 4'd9, 5'd1, 1'b0);
    tests_run++; if (alu_flag_in !== 2'b01) begin fails++; $display("FAIL chain_flag: got %b expected 01", alu_flag_in); end
    issue(4'd1, 4'd1, 5'd1, 1'b0);
    tests_run++; if (res_data !== 4'd3) begin fails++; $display("FAIL chain_result: got %0d expected 3", res_data); end
    issue(4'hF, 4'd1, 5'd0, 1'b0);
    res_ready = 1'b0; flag_clr = 1'b1;
    @(posedge clk);
    m_fc = 1'b0; m_fz = 1'b0;
    @(negedge clk);
    flag_clr = 1'b0;
    tests_run++; if ({alu_flag_in, res_valid, res_data, op_count} !== {2'b00, 1'b1, 4'd0, 8'd3}) begin fails++; $display("FAIL clr_done: got fi=%b v=%b r=%h cnt=%0d expected fi=00 v=1 r=0 cnt=3", alu_flag_in, res_valid, res_data, op_count); end
  endtask

  task automatic test_clr_capture();
    issue(4'd8, 4'd8, 5'd0, 1'b1);
    tests_run++; if ({flag_c, flag_z} !== 2'b11) begin fails++; $display("FAIL clr_vs_capture: got c=%b z=%b expected 1/1", flag_c, flag_z); end
  endtask

  task automatic test_reset_in_exec();
    do_reset();
    in_a = 4'd5; in_b = 4'd6; in_ctrl = 5'd3; in_valid = 1'b1; res_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0; rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    tests_run++; if ({alu_a, alu_b, alu_control, res_data, flag_c, flag_z, op_count} !== '0) begin fails++; $display("FAIL rst_exec_regs: got a=%h b=%h ctl=%h r=%h cnt=%0d expected all 0", alu_a, alu_b, alu_control, res_data, op_count); end
    @(posedge clk);
    @(negedge clk);
    tests_run++; if ({res_valid, in_ready, op_count} !== {2'b01, 8'd0}) begin fails++; $display("FAIL rst_exec_idle: got v=%b r=%b cnt=%0d expected v=0 r=1 cnt=0", res_valid, in_ready, op_count); end
  endtask

  task automatic test_count_wrap();
    logic [1:0] seq [5];
    seq = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
    do_reset();
    for (int i = 0; i < 5; i++) begin
      issue(4'($urandom), 4'($urandom), 5'($urandom), 1'b0);
      tests_run++; if (op_count2 !== seq[i]) begin fails++; $display("FAIL wrap_seq%0d: got %0d expected %0d", i, op_count2, seq[i]); end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 2) == 0) hold_done($urandom_range(1, 3), 1'b1);
      if ($urandom_range(0, 2) == 0) idle_gap($urandom_range(1, 3));
      issue(4'($urandom), 4'($urandom), 5'($urandom), 1'($urandom_range(0, 3) == 0));
    end
    idle_gap(1);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_carry_chain();
    test_clr_capture();
    test_reset_in_exec();
    test_count_wrap();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule
`default_nettype wire
